enc_bpv_packer: RTL and testbench
=================================

Name: enc_bpv_packer

Overview:
- Encoder-side counterpart of the BP-mode suffix decoder.
- Takes one block's block-prediction vectors (one for 2x2, two for 2x1) plus an already-encoded, MSB-aligned coefficient payload.
- Packs them MSB-first into a 128-bit suffix: BPV field(s) first, coefficients immediately after. Reports the total bit count.
- Sits between the BP search/ECG encoder and the substream muxer. Valid/ready on both sides.

Parameters:
- SSM_IDX, 0, substream index tag; no functional effect.
- BPV_NUM_BITS, 6, raw BPV field width; the FLS width is BPV_NUM_BITS-1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  block descriptor valid
- in_ready  output  1  block can accept a descriptor
- mode_bp  input  1  block is BP mode; 0 = transform pass-through
- is_fls  input  1  first line of slice; BPV coded as value-32 in 5 bits
- use2x2  input  1  1: single BPV; 0: two BPVs (2x1)
- bpv0  input  6  first BPV value
- bpv1  input  6  second BPV value; ignored when use2x2=1
- coef_bits  input  128  coefficient payload, MSB-aligned
- coef_size  input  8  valid payload bits, 0..128
- out_valid  output  1  packed suffix valid
- out_ready  input  1  downstream accepts
- out_suffix  output  128  packed suffix, MSB-aligned, zero below out_size
- out_size  output  8  total bits, 0..128
- out_err  output  1  range or overflow error for this block

Behaviour:
- FSM states: IDLE, BPV0, BPV1, MERGE, OUT. Each non-OUT state lasts exactly one cycle.
- Reset (async, any time, including mid-block):
  - state=IDLE; out_valid=0, out_suffix=0, out_size=0, out_err=0.
  - The captured descriptor is discarded and no partial output is ever presented.
- in_ready=1 only in IDLE (decoded from state). A descriptor is accepted on the edge where in_valid&in_ready.
- in_valid outside IDLE is ignored; no queuing.
- Transition on accept: mode_bp=1 → BPV0; mode_bp=0 → MERGE.
- Field width: w = is_fls ? BPV_NUM_BITS-1 : BPV_NUM_BITS, so 5 or 6.
- Field value:
  - is_fls=1: field = bpv-32, low 5 bits.
  - is_fls=0: field = bpv.
- BPV0 state:
  - Writes field(bpv0) into accumulator bits [127 -: w]; ptr=w.
  - Next state: use2x2 → MERGE, else BPV1.
- BPV1 state:
  - Writes field(bpv1) at [127-w -: w]; ptr=2w.
  - Next state: MERGE.
- MERGE state:
  - Masks coef_bits to its top coef_size bits and ORs (coef_bits_masked >> ptr) into the accumulator.
  - total = ptr + coef_size, computed 9 bits wide.
  - Next state: OUT.
- Width rule for mode_bp=0: ptr=0, so out_suffix = masked coef_bits and out_size = coef_size.
- out_err is set when:
  - is_fls=1 and any used bpv < 32 (the field still uses the low 5 bits of bpv-32 mod 64); or
  - total > 128, in which case out_size saturates to 128 and bits shifted past bit 0 are dropped.
- OUT state:
  - out_valid=1. out_suffix, out_size and out_err hold stable until out_valid&out_ready.
  - Then state=IDLE, out_valid=0 on the next edge.
- Latency, counted in edges from the accept edge to out_valid first high: non-BP 2, BP 2x2 3, BP 2x1 4.
- Throughput: the next accept is possible the cycle after the output handshake; there is no accept/output overlap.
- Outputs are registered; no combinational path from in_* to out_*.

Test Plan:
- BP 2x2 non-FLS:
  - Stimulus: bpv0=6'h2A; coef_size=10; coef_bits[127:118]=10'b1011001110; garbage in the lower bits.
  - Required: out_valid 3 edges after accept; out_suffix[127:112]=16'b101010_1011001110, rest 0; out_size=16; out_err=0.
- BP 2x1 FLS:
  - Stimulus: bpv0=33, bpv1=63, coef_size=0.
  - Required: out_suffix[127:118]=10'b00001_11111, rest 0; out_size=10; out_valid at 4 edges; out_err=0.
- FLS range error:
  - Stimulus: is_fls=1, use2x2=1, bpv0=5.
  - Required: out_err=1; field=5'b00101 (low bits of 5-32 mod 64 = 37); out_size=5+coef_size.
- Overflow:
  - Stimulus: BP 2x1 non-FLS (ptr=12), coef_size=125, coef_bits all 1s.
  - Required: out_size=128; out_err=1; out_suffix[115:0] all 1s.
- Pass-through plus backpressure:
  - Stimulus: mode_bp=0, coef_size=64, out_ready held 0 for 5 cycles.
  - Required: out_valid at 2 edges; outputs stable during the stall; in_ready=0 throughout; after the out_ready pulse, in_ready=1 the next cycle.
- Mid-block reset:
  - Stimulus: assert rst_n=0 while in BPV1.
  - Required: out_valid=0 immediately (async); in_ready=1 after release; no stale output; a following block packs correctly.

Source files
------------

// File: rtl/enc_bpv_packer_if.sv
// enc_bpv_packer_if: block descriptor in / packed suffix out, valid/ready on both sides
//   master: drives the descriptor (in_valid, mode_bp, is_fls, use2x2, bpv0, bpv1,
//           coef_bits, coef_size) and out_ready; sees in_ready and out_*
//   slave : the packer; drives in_ready, out_valid, out_suffix, out_size, out_err
interface enc_bpv_packer_if #(
    parameter int BPV_NUM_BITS = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode_bp;
    logic                    is_fls;
    logic                    use2x2;
    logic [BPV_NUM_BITS-1:0] bpv0;
    logic [BPV_NUM_BITS-1:0] bpv1;
    logic [127:0]            coef_bits;
    logic [7:0]              coef_size;
    logic                    out_valid;
    logic                    out_ready;
    logic [127:0]            out_suffix;
    logic [7:0]              out_size;
    logic                    out_err;

    modport master (
        output in_valid, mode_bp, is_fls, use2x2, bpv0, bpv1, coef_bits, coef_size, out_ready,
        input  in_ready, out_valid, out_suffix, out_size, out_err
    );

    modport slave (
        input  in_valid, mode_bp, is_fls, use2x2, bpv0, bpv1, coef_bits, coef_size, out_ready,
        output in_ready, out_valid, out_suffix, out_size, out_err
    );
endinterface

// File: rtl/enc_bpv_packer.sv
// enc_bpv_packer: packs BP-mode BPV field(s) and an MSB-aligned coefficient payload into a 128-bit suffix
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : enc_bpv_packer_if.slave (descriptor in, packed suffix/size/err out)
module enc_bpv_packer #(
    parameter int SSM_IDX      = 0,
    parameter int BPV_NUM_BITS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    enc_bpv_packer_if.slave bus
);
    localparam int N = BPV_NUM_BITS;

    typedef enum logic [2:0] {IDLE, BPV0, BPV1, MERGE, OUT} state_t;

    state_t         state;
    logic           fls_q;
    logic           use2x2_q;
    logic [N-1:0]   bpv0_q;
    logic [N-1:0]   bpv1_q;
    logic [127:0]   coef_q;
    logic [7:0]     size_q;
    logic [127:0]   acc;
    logic [7:0]     ptr;
    logic           err;
    logic [7:0]     w;
    logic [N-1:0]   bpv_sel;
    logic [N-1:0]   field;
    logic [127:0]   field_sh;
    logic [127:0]   mask;
    logic [127:0]   merged;
    logic [8:0]     total;

    assign bus.in_ready = (state == IDLE);

    // Subtracting 2^(N-1) only touches the top bit, so the FLS field is just the
    // low N-1 bits of the BPV; it is left-aligned so one shift serves both widths.
    always_comb begin
        w        = fls_q ? 8'(N - 1) : 8'(N);
        bpv_sel  = (state == BPV1) ? bpv1_q : bpv0_q;
        field    = fls_q ? {bpv_sel[N-2:0], 1'b0} : bpv_sel;
        field_sh = {field, {(128 - N){1'b0}}} >> ptr;
        mask     = ~({128{1'b1}} >> size_q);
        merged   = acc | ((coef_q & mask) >> ptr);
        total    = {1'b0, ptr} + {1'b0, size_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fls_q          <= 1'b0;
            use2x2_q       <= 1'b0;
            bpv0_q         <= '0;
            bpv1_q         <= '0;
            coef_q         <= '0;
            size_q         <= '0;
            acc            <= '0;
            ptr            <= '0;
            err            <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_suffix <= '0;
            bus.out_size   <= '0;
            bus.out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    fls_q    <= bus.is_fls;
                    use2x2_q <= bus.use2x2;
                    bpv0_q   <= bus.bpv0;
                    bpv1_q   <= bus.bpv1;
                    coef_q   <= bus.coef_bits;
                    size_q   <= bus.coef_size;
                    acc      <= '0;
                    ptr      <= '0;
                    err      <= 1'b0;
                    state    <= bus.mode_bp ? BPV0 : MERGE;
                end
                BPV0: begin
                    acc   <= acc | field_sh;
                    ptr   <= w;
                    err   <= fls_q & ~bpv0_q[N-1];
                    state <= use2x2_q ? MERGE : BPV1;
                end
                BPV1: begin
                    acc   <= acc | field_sh;
                    ptr   <= ptr + w;
                    err   <= err | (fls_q & ~bpv1_q[N-1]);
                    state <= MERGE;
                end
                MERGE: begin
                    // bits shifted past bit 0 are simply lost; size saturates at 128
                    bus.out_suffix <= merged;
                    bus.out_size   <= (total > 9'd128) ? 8'd128 : total[7:0];
                    bus.out_err    <= err | (total > 9'd128);
                    bus.out_valid  <= 1'b1;
                    state          <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enc_bpv_packer.sv
// tb_enc_bpv_packer: directed self-checking bench for enc_bpv_packer
module tb_enc_bpv_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    enc_bpv_packer_if bus ();

    enc_bpv_packer #(.SSM_IDX(0), .BPV_NUM_BITS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic run_block(input string tag, input logic mb, input logic fls, input logic u2,
                             input logic [5:0] b0, input logic [5:0] b1,
                             input logic [127:0] cb, input logic [7:0] cs,
                             input int exp_lat, input logic [127:0] exp_suf,
                             input logic [7:0] exp_size, input logic exp_err, input logic ack);
        int lat;
        @(negedge clk);
        bus.mode_bp   = mb;
        bus.is_fls    = fls;
        bus.use2x2    = u2;
        bus.bpv0      = b0;
        bus.bpv1      = b1;
        bus.coef_bits = cb;
        bus.coef_size = cs;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 16) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " suffix"}, bus.out_suffix, exp_suf);
        check({tag, " size"}, 128'(bus.out_size), 128'(exp_size));
        check({tag, " err"}, 128'(bus.out_err), 128'(exp_err));
        if (ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
            check({tag, " valid drop"}, 128'(bus.out_valid), 128'(0));
            check({tag, " in_ready back"}, 128'(bus.in_ready), 128'(1));
        end
    endtask

    logic [127:0] exp5;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mode_bp   = 1'b0;
        bus.is_fls    = 1'b0;
        bus.use2x2    = 1'b0;
        bus.bpv0      = '0;
        bus.bpv1      = '0;
        bus.coef_bits = '0;
        bus.coef_size = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 128'(bus.out_valid), 128'(0));
        check("rst out_suffix", bus.out_suffix, 128'h0);
        check("rst out_size", 128'(bus.out_size), 128'(0));
        check("rst out_err", 128'(bus.out_err), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst in_ready", 128'(bus.in_ready), 128'(1));

        // BP 2x2 non-FLS: 101010 then 1011001110, garbage below the payload
        run_block("bp2x2", 1'b1, 1'b0, 1'b1, 6'h2A, 6'h3F,
                  {10'b1011001110, 118'h2A5A5A5A5A5A5A5A5A5A5A5A5A5A5}, 8'd10,
                  3, {16'hAACE, 112'h0}, 8'd16, 1'b0, 1'b1);

        // BP 2x1 FLS: 33 -> 00001, 63 -> 11111, no payload
        run_block("bp2x1fls", 1'b1, 1'b1, 1'b0, 6'd33, 6'd63, {128{1'b1}}, 8'd0,
                  4, {10'b0000111111, 118'h0}, 8'd10, 1'b0, 1'b1);

        // FLS range error: 5 -> low bits of 37 = 00101, then 3 payload bits 111
        run_block("flserr", 1'b1, 1'b1, 1'b1, 6'd5, 6'd0, {3'b111, 125'h0}, 8'd3,
                  3, {8'h2F, 120'h0}, 8'd8, 1'b1, 1'b1);

        // Overflow: 12 BPV bits + 125 payload bits, saturate and drop the tail
        run_block("ovf", 1'b1, 1'b0, 1'b0, 6'h15, 6'h2E, {128{1'b1}}, 8'd125,
                  4, {6'h15, 6'h2E, {116{1'b1}}}, 8'd128, 1'b1, 1'b1);

        // Pass-through with backpressure; a pending in_valid must be ignored
        exp5 = {64'hDEADBEEF01234567, 64'h0};
        run_block("pass", 1'b0, 1'b1, 1'b0, 6'd0, 6'd0,
                  {64'hDEADBEEF01234567, 64'hFFFFFFFFFFFFFFFF}, 8'd64,
                  2, exp5, 8'd64, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall valid", 128'(bus.out_valid), 128'(1));
            check("stall suffix", bus.out_suffix, exp5);
            check("stall size", 128'(bus.out_size), 128'(64));
            check("stall in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        check("pass valid drop", 128'(bus.out_valid), 128'(0));
        check("pass in_ready back", 128'(bus.in_ready), 128'(1));

        // Mid-block reset while in BPV1
        @(negedge clk);
        bus.mode_bp = 1'b1;
        bus.is_fls  = 1'b0;
        bus.use2x2  = 1'b0;
        bus.bpv0    = 6'h11;
        bus.bpv1    = 6'h22;
        bus.coef_size = 8'd4;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst in_ready", 128'(bus.in_ready), 128'(1));
        check("midrst suffix", bus.out_suffix, 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst no stale", 128'(bus.out_valid), 128'(0));
        check("midrst idle", 128'(bus.in_ready), 128'(1));
        run_block("postrst", 1'b1, 1'b0, 1'b1, 6'h2A, 6'h00,
                  {10'b1011001110, 118'h0}, 8'd10,
                  3, {16'hAACE, 112'h0}, 8'd16, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
